// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the iterative FP arithmetic units.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_NORM,
    S_DIVIDE,
    S_NORMALIZE,
    S_DENORM,
    S_PACK
  } fp_state_t;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  // binary32 field slices
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

endpackage

// File: rtl/fp_divider_if.sv
// Request/result bundle of the FP divider: input_valid, in_a, in_b in;
// data_out, output_valid, busy out. Latency: n/a (wiring only).
// Backpressure: none; requests presented while busy are dropped by the slave.
interface fp_divider_if;
  logic        input_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] data_out;
  logic        output_valid;
  logic        busy;

  modport master (
    output input_valid, in_a, in_b,
    input  data_out, output_valid, busy
  );

  modport slave (
    input  input_valid, in_a, in_b,
    output data_out, output_valid, busy
  );
endinterface

// File: rtl/fp_div_mant_core.sv
// Restoring radix-2 mantissa divider: q = floor(ma/mb * 2^25), 26 bits MSB-first.
// Latency: 26 cycles after the start cycle; done is high in the 26th.
// Backpressure: none; start reloads the core at any time.
// Ports: clk, reset (sync, active-high), start, ma[23:0], mb[23:0] -> q[25:0], done.
module fp_div_mant_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic [25:0] q,
  output logic        done
);

  logic [24:0] rem;
  logic [24:0] dvs;
  logic [4:0]  cnt;
  logic        running;
  logic        ge;

  // Both mantissas are normalized, so rem stays below 2*mb and fits 25 bits.
  assign ge   = (rem >= dvs);
  assign done = running && (cnt == 5'd25);

  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      dvs     <= '0;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= {1'b0, ma};
      dvs     <= {1'b0, mb};
      q       <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      rem <= ge ? ((rem - dvs) << 1) : (rem << 1);
      q   <= {q[24:0], ge};
      cnt <= cnt + 5'd1;
      if (cnt == 5'd25) running <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_divider.sv
// IEEE-754 binary32 divider data_out = in_a / in_b, truncating, full subnormal support.
// Latency: 30 cycles normal, 3 special, +1 per NORM shift, +1 per DENORM shift (max 25).
// Backpressure: none; input_valid is sampled only in IDLE, otherwise dropped.
// Ports: clk, reset (sync, active-high), dif (slave: operands in, result/valid/busy out).
module fp_divider
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fp_divider_if.slave  dif
);

  fp_state_t state, state_nx;

  logic [31:0] a_r, b_r;
  logic        sign_r;
  logic        special_r;
  logic [31:0] special_val_r;
  logic [23:0] ma_r, mb_r, ma_c, mb_c;
  logic signed [9:0] ea_r, eb_r, ea_c, eb_c, e_r, e_norm;
  logic [25:0] q_r, q_core, q_norm;
  logic [31:0] data_out_r;
  logic        output_valid_r;
  logic        core_start, core_done, norm_ready;

  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        sign_c;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        unp_special;
  logic [31:0] unp_special_val;

  assign exp_a  = a_r[EXP_MSB:EXP_LSB];
  assign exp_b  = b_r[EXP_MSB:EXP_LSB];
  assign frac_a = a_r[FRAC_MSB:FRAC_LSB];
  assign frac_b = b_r[FRAC_MSB:FRAC_LSB];
  assign sign_c = a_r[SIGN_BIT] ^ b_r[SIGN_BIT];

  assign a_nan  = (exp_a == 8'(EXP_MAX)) && (frac_a != '0);
  assign b_nan  = (exp_b == 8'(EXP_MAX)) && (frac_b != '0);
  assign a_inf  = (exp_a == 8'(EXP_MAX)) && (frac_a == '0);
  assign b_inf  = (exp_b == 8'(EXP_MAX)) && (frac_b == '0);
  assign a_zero = (exp_a == 8'd0) && (frac_a == '0);
  assign b_zero = (exp_b == 8'd0) && (frac_b == '0);

  // Special results in priority order; NaN is the only one without sign.
  always_comb begin
    unp_special     = 1'b1;
    unp_special_val = QNAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      unp_special_val = QNAN;
    else if (b_zero || a_inf)
      unp_special_val = POS_INF | {sign_c, 31'b0};
    else if (a_zero || b_inf)
      unp_special_val = {sign_c, 31'b0};
    else
      unp_special = 1'b0;
  end

  // Mantissa/exponent values for this cycle: decoded in UNPACK, shifted in NORM.
  // The core is started from these so the last NORM shift costs no extra cycle.
  always_comb begin
    ma_c = ma_r;
    mb_c = mb_r;
    ea_c = ea_r;
    eb_c = eb_r;
    if (state == S_UNPACK) begin
      ma_c = {exp_a != 8'd0, frac_a};
      mb_c = {exp_b != 8'd0, frac_b};
      ea_c = (exp_a == 8'd0) ? 10'sd1 : $signed({2'b00, exp_a});
      eb_c = (exp_b == 8'd0) ? 10'sd1 : $signed({2'b00, exp_b});
    end else if (state == S_NORM) begin
      if (!ma_r[23]) begin
        ma_c = ma_r << 1;
        ea_c = ea_r - 10'sd1;
      end
      if (!mb_r[23]) begin
        mb_c = mb_r << 1;
        eb_c = eb_r - 10'sd1;
      end
    end
  end

  assign norm_ready = ma_c[23] && mb_c[23];
  assign core_start = norm_ready &&
                      (((state == S_UNPACK) && !unp_special) || (state == S_NORM));

  fp_div_mant_core u_core (
    .clk   (clk),
    .reset (reset),
    .start (core_start),
    .ma    (ma_c),
    .mb    (mb_c),
    .q     (q_core),
    .done  (core_done)
  );

  // Quotient lies in (0.5, 2): at most one left shift brings the integer bit to q[25].
  always_comb begin
    q_norm = q_core;
    e_norm = e_r;
    if (!q_core[25]) begin
      q_norm = q_core << 1;
      e_norm = e_r - 10'sd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (dif.input_valid) state_nx = S_UNPACK;
      S_UNPACK: begin
        if (unp_special)      state_nx = S_PACK;
        else if (!norm_ready) state_nx = S_NORM;
        else                  state_nx = S_DIVIDE;
      end
      S_NORM:      if (norm_ready) state_nx = S_DIVIDE;
      S_DIVIDE:    if (core_done) state_nx = S_NORMALIZE;
      S_NORMALIZE: begin
        if (e_norm >= 10'(EXP_MAX)) state_nx = S_PACK;
        else if (e_norm <= 10'sd0)  state_nx = S_DENORM;
        else                        state_nx = S_PACK;
      end
      // e < -24 means a shift count above 25: flushed to zero in one cycle.
      S_DENORM:    if ((e_r < -10'sd24) || (e_r == 10'sd0)) state_nx = S_PACK;
      S_PACK:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r            <= '0;
      b_r            <= '0;
      sign_r         <= 1'b0;
      special_r      <= 1'b0;
      special_val_r  <= '0;
      ma_r           <= '0;
      mb_r           <= '0;
      ea_r           <= '0;
      eb_r           <= '0;
      e_r            <= '0;
      q_r            <= '0;
      data_out_r     <= '0;
      output_valid_r <= 1'b0;
    end else begin
      output_valid_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dif.input_valid) begin
            a_r <= dif.in_a;
            b_r <= dif.in_b;
          end
        end
        S_UNPACK, S_NORM: begin
          if (state == S_UNPACK) begin
            sign_r        <= sign_c;
            special_r     <= unp_special;
            special_val_r <= unp_special_val;
          end
          ma_r <= ma_c;
          mb_r <= mb_c;
          ea_r <= ea_c;
          eb_r <= eb_c;
          e_r  <= ea_c - eb_c + 10'(EXP_BIAS);
        end
        S_NORMALIZE: begin
          q_r <= q_norm;
          e_r <= e_norm;
          if (e_norm >= 10'(EXP_MAX)) begin
            special_r     <= 1'b1;
            special_val_r <= POS_INF | {sign_r, 31'b0};
          end
        end
        S_DENORM: begin
          if (e_r < -10'sd24) begin
            q_r <= '0;
            e_r <= '0;
          end else begin
            q_r <= q_r >> 1;
            // The shift that reaches exponent 1 leaves e_r at 0, the subnormal field value.
            if (e_r != 10'sd0) e_r <= e_r + 10'sd1;
          end
        end
        S_PACK: begin
          data_out_r     <= special_r ? special_val_r : {sign_r, e_r[7:0], q_r[24:2]};
          output_valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dif.data_out     = data_out_r;
  assign dif.output_valid = output_valid_r;
  assign dif.busy         = (state != S_IDLE);

endmodule

// File: doc/fp_divider.md
# fp_divider

IEEE-754 single-precision divider (`data_out = in_a / in_b`) and the inverse-operation companion to the team's iterative FP multiplier, with the same `input_valid` / `output_valid` handshake so both units drop into the same arithmetic datapath slot. The block is an iterative FSM with a restoring radix-2 mantissa divide. Subnormal handling is full; special values are handled; rounding is truncation (round toward zero), matching the multiplier.

## Interface
- No parameters; fixed binary32.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `input_valid` input 1: request. Sampled only in IDLE.
- `in_a` input 32: dividend. Captured on acceptance.
- `in_b` input 32: divisor. Captured on acceptance.
- `data_out` output 32: result. Held until the next result is written.
- `output_valid` output 1: one-cycle pulse when `data_out` is updated.
- `busy` output 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: `input_valid` causes capture of operands, then UNPACK; otherwise stay.
  - UNPACK: decode both operands.
    - Special case: go to PACK with the special result.
    - Subnormal operand present: NORM.
    - Otherwise: DIVIDE.
  - NORM: shift left one bit per cycle the subnormal mantissa(s) lacking bit 23 and decrement that operand's exponent. Go to DIVIDE when both have bit 23 set.
  - DIVIDE: 26 cycles, counted by a 5-bit counter.
  - NORMALIZE: go to DENORM if the result exponent ≤ 0, else PACK.
  - DENORM: shift right one bit per cycle until exponent = 1, then write biased 0. Go to PACK.
  - PACK: register `data_out` and assert `output_valid`, then IDLE.
- Unpack:
  - Mantissa = {hidden bit, frac}, 24 bits.
  - A subnormal takes effective exponent 1 with hidden bit 0.
  - Sign = `a[31]` ^ `b[31]`, applied to all results except NaN.
- Exponent: 10-bit signed, `e = ea - eb + 127`. No intermediate wrap is permitted.
- Divide:
  - Remainder `r` is 25 bits, initialised to `ma`.
  - Each cycle: if `r >= mb`, the quotient bit is 1 and `r -= mb`. Then `r <<= 1`.
  - The 26 quotient bits are MSB-first: 1 integer bit and 25 fraction bits.
- Normalize:
  - If `q[25] == 0`, shift `q` left 1 and decrement `e`.
  - If `e ≥ 255`, the result is ±inf (0x7F800000 | sign).
- Denorm:
  - Shift count is `1 - e`.
  - A shift count > 25 forces ±0 immediately.
- Pack: `{sign, e[7:0], q[24:2]}`. Truncate and discard the remaining bits.
- Special results, in priority order:
  - Either operand NaN → 0x7FC00000.
  - 0/0 or inf/inf → 0x7FC00000.
  - x/0 → ±inf.
  - inf/x → ±inf.
  - 0/x → ±0.
  - x/inf → ±0.
- `input_valid` while busy is ignored. The request is not queued.

## Timing
- Reset values: state IDLE, `data_out` 0x00000000, `output_valid` 0, `busy` 0.
- Reset wins over every other event in the same cycle. An operation in flight is discarded, and no `output_valid` follows the reset.
- Latency is counted from the cycle `input_valid` is sampled high in IDLE (cycle 0) to the cycle `output_valid` is high:
  - Normal/normal operands, normal result: 30 cycles.
  - Special case: 3 cycles.
  - NORM adds 1 cycle per leading-zero shift.
  - DENORM adds 1 cycle per shift, capped at 25.
- `output_valid` is high in the first IDLE cycle after PACK. A new `input_valid` is accepted in that same cycle.
- `busy` rises the cycle after acceptance. It is low when `output_valid` is high.

## Structure
- Shared package `fp_pkg` holds:
  - The `fp_state_t` enum.
  - `EXP_BIAS` = 127, `EXP_MAX` = 255.
  - `QNAN` = 32'h7FC00000, `POS_INF` = 32'h7F800000.
  - The binary32 field-slice localparams, shared with the multiplier.
- One sub-module, `fp_div_mant_core`, holds the restoring-divide remainder/quotient registers and counter. Its interface is `start`, `ma`, `mb` → `q[25:0]`, `done`.
- Top level holds the FSM, unpack, exponent path, normalize/denorm, and pack.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) → 0x40400000, `output_valid` exactly 30 cycles after acceptance, `busy` high cycles 1–29.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA (truncated, not 0x3EAAAAAB).
- 0xBF800000 / 0x00000000 → 0xFF800000.
- 0x00000000 / 0x00000000 → 0x7FC00000, latency 3.
- Overflow: 0x7F000000 / 0x3E800000 → 0x7F800000.
- Underflow: 0x00800000 / 0x40000000 → 0x00400000.
- Reset asserted mid-DIVIDE → next cycle shows `busy` 0, `output_valid` 0, `data_out` 0, and no later pulse.
